// File: rtl/axi_l_slave_bfm_if.sv
// axi_l_slave_bfm_if -- AXI4-Lite style bus bundle for axi_l_slave_bfm.
//
// Carries the five channels (AR, AW, W, B, R) between a master and the
// slave memory model.
//   master modport : drives addresses, write data/strobes, valids on
//                    AR/AW/W and readies on B/R.
//   slave modport  : drives readies on AR/AW/W, and the B and R
//                    channel payloads and valids.
// arprot/awprot are carried for completeness; the slave ignores them.
interface axi_l_slave_bfm_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
);

    // AR channel
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    // AW channel
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    // W channel
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;

    // B channel
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    // R channel
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arprot, arvalid,
        input  arready,
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  araddr, arprot, arvalid,
        output arready,
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        output rdata, rresp, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_l_slave_bfm.sv
// axi_l_slave_bfm -- AXI4-Lite slave backed by a small word memory.
//
// Ports:
//   clk     : single clock, all state on the rising edge.
//   rst_n   : asynchronous active-low reset; clears state, outputs and
//             every memory word.
//   bus     : axi_l_slave_bfm_if.slave (AR, AW, W, B, R channels).
//   wr_cnt  : number of completed B handshakes (wraps at 2^32).
//   rd_cnt  : number of completed R handshakes (wraps at 2^32).
//
// Addressing: word index = addr >> log2(MASK_WIDTH). Indices at or above
// MEM_DEPTH get SLVERR and never touch memory; reads of them return 0.
//
// Write side: AW and W are captured independently (either order or the
// same cycle). The edge that completes the pair also performs the memory
// update and raises bvalid, so a write costs two cycles with bready held.
// Read side: an AR handshake loads rdata/rresp and raises rvalid on the
// same edge; the R handshake returns to idle, again two cycles per read.
// Both sides run concurrently. Memory is written with non-blocking
// assignments, so a read sampling the word on the same edge as a write
// returns the old contents.
module axi_l_slave_bfm #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int MASK_WIDTH = DATA_WIDTH / 8,
    parameter int MEM_DEPTH  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    axi_l_slave_bfm_if.slave bus,
    output logic [31:0]      wr_cnt,
    output logic [31:0]      rd_cnt
);

    localparam int OFFS  = $clog2(MASK_WIDTH);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_COLLECT,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rstate_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ------------------------------------------------------------------
    // Write side state
    // ------------------------------------------------------------------
    wstate_t               wstate;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [MASK_WIDTH-1:0] wstrb_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic [31:0]           wr_cnt_q;

    // ------------------------------------------------------------------
    // Read side state
    // ------------------------------------------------------------------
    rstate_t               rstate;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [31:0]           rd_cnt_q;

    // ------------------------------------------------------------------
    // Write-side combinational helpers
    // ------------------------------------------------------------------
    logic                  aw_fire;
    logic                  w_fire;
    logic                  aw_have;
    logic                  w_have;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [MASK_WIDTH-1:0] wr_strb;
    logic [ADDR_WIDTH-1:0] wr_word;
    logic                  wr_in_range;
    logic [IDX_W-1:0]      wr_idx;

    // A handshake this cycle counts as "held" so the write can complete on
    // the same edge that captures the second half of the pair; the captured
    // copy is used for whichever half arrived earlier.
    assign aw_fire     = bus.awvalid && awready_q;
    assign w_fire      = bus.wvalid && wready_q;
    assign aw_have     = aw_held || aw_fire;
    assign w_have      = w_held || w_fire;
    assign wr_addr     = aw_held ? awaddr_q : bus.awaddr;
    assign wr_data     = w_held ? wdata_q : bus.wdata;
    assign wr_strb     = w_held ? wstrb_q : bus.wstrb;
    assign wr_word     = wr_addr >> OFFS;
    assign wr_in_range = (wr_word < ADDR_WIDTH'(MEM_DEPTH));
    assign wr_idx      = wr_word[IDX_W-1:0];

    // ------------------------------------------------------------------
    // Read-side combinational helpers
    // ------------------------------------------------------------------
    logic                  ar_fire;
    logic [ADDR_WIDTH-1:0] rd_word;
    logic                  rd_in_range;
    logic [IDX_W-1:0]      rd_idx;

    assign ar_fire     = bus.arvalid && arready_q;
    assign rd_word     = bus.araddr >> OFFS;
    assign rd_in_range = (rd_word < ADDR_WIDTH'(MEM_DEPTH));
    assign rd_idx      = rd_word[IDX_W-1:0];

    // Protection attributes carry no meaning for this model.
    logic unused_prot;
    assign unused_prot = ^{bus.arprot, bus.awprot};

    // ------------------------------------------------------------------
    // Write FSM and memory
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate    <= W_COLLECT;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            wr_cnt_q  <= '0;
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem[IDX_W'(i)] <= '0;
            end
        end else begin
            case (wstate)
                W_COLLECT: begin
                    if (aw_fire) begin
                        aw_held  <= 1'b1;
                        awaddr_q <= bus.awaddr;
                    end
                    if (w_fire) begin
                        w_held  <= 1'b1;
                        wdata_q <= bus.wdata;
                        wstrb_q <= bus.wstrb;
                    end
                    if (aw_have && w_have) begin
                        wstate    <= W_RESP;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        if (wr_in_range) begin
                            bresp_q <= RESP_OKAY;
                            for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
                                if (wr_strb[i]) begin
                                    mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                                end
                            end
                        end else begin
                            bresp_q <= RESP_SLVERR;
                        end
                    end else begin
                        // Each ready drops once its own half is captured.
                        awready_q <= !aw_have;
                        wready_q  <= !w_have;
                    end
                end

                W_RESP: begin
                    if (bus.bready) begin
                        wstate    <= W_COLLECT;
                        bvalid_q  <= 1'b0;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wr_cnt_q  <= wr_cnt_q + 32'd1;
                    end
                end

                default: begin
                    wstate <= W_COLLECT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate    <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            rd_cnt_q  <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    // arready is low only for the first cycle out of reset.
                    arready_q <= 1'b1;
                    if (ar_fire) begin
                        rstate    <= R_RESP;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        if (rd_in_range) begin
                            rdata_q <= mem[rd_idx];
                            rresp_q <= RESP_OKAY;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= RESP_SLVERR;
                        end
                    end
                end

                R_RESP: begin
                    if (bus.rready) begin
                        rstate    <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rd_cnt_q  <= rd_cnt_q + 32'd1;
                    end
                end

                default: begin
                    rstate <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;
    assign wr_cnt      = wr_cnt_q;
    assign rd_cnt      = rd_cnt_q;

endmodule

// File: tb/tb_axi_l_slave_bfm.sv
// tb_axi_l_slave_bfm -- directed self-checking bench for axi_l_slave_bfm.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi_l_slave_bfm;

    localparam int DW = 512;
    localparam int AW = 64;
    localparam int MW = DW / 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wr_cnt;
    logic [31:0] rd_cnt;

    always #5 clk = ~clk;

    axi_l_slave_bfm_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_WIDTH(MW)) bus ();

    axi_l_slave_bfm #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MASK_WIDTH(MW),
        .MEM_DEPTH (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .wr_cnt(wr_cnt),
        .rd_cnt(rd_cnt)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_wr = 32'd0;
    logic [31:0] exp_rd = 32'd0;

    logic [DW-1:0] pat_a5 = {MW{8'hA5}};
    logic [DW-1:0] pat_5a = {MW{8'h5A}};
    logic [DW-1:0] pat_3c = {MW{8'h3C}};
    logic [DW-1:0] pat_42 = {MW{8'h42}};
    logic [DW-1:0] pat_77 = {MW{8'h77}};
    logic [DW-1:0] pat_ff = {MW{8'hFF}};
    logic [DW-1:0] pat_ee11 = {{(MW-1){8'hEE}}, 8'h11};
    logic [DW-1:0] pat_b0_11 = {{(MW-1){8'h00}}, 8'h11};
    logic [DW-1:0] zero_w = '0;

    // Two-cycle read with rready raised after rvalid is observed.
    task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                           output logic [1:0] resp, output logic vld);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        @(negedge clk);
        vld  = bus.rvalid;
        data = bus.rdata;
        resp = bus.rresp;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        exp_rd = exp_rd + 32'd1;
    endtask

    // Two-cycle write, AW and W presented together.
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [MW-1:0] strb, output logic [1:0] resp,
                            output logic vld);
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b0;
        @(negedge clk);
        vld  = bus.bvalid;
        resp = bus.bresp;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        exp_wr = exp_wr + 32'd1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 0",
                     {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp});
        end
        n_cmp++;
        if ({wr_cnt, rd_cnt} !== 64'd0) begin
            n_err++;
            $display("FAIL reset_cnt: got %h/%h expected 0/0", wr_cnt, rd_cnt);
        end
        n_cmp++;
        if (bus.rdata !== zero_w) begin
            n_err++;
            $display("FAIL reset_rdata: got %h expected 0", bus.rdata);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
            n_err++;
            $display("FAIL ready_before_edge: got %b expected 000", {bus.awready, bus.wready, bus.arready});
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            n_err++;
            $display("FAIL ready_after_edge: got %b expected 111", {bus.awready, bus.wready, bus.arready});
        end
    endtask

    task automatic test_same_cycle();
        logic [DW-1:0] d;
        logic [1:0]    r;
        logic          v;
        do_write(64'h40, pat_a5, '1, r, v);
        n_cmp++;
        if ({v, r} !== 3'b100) begin
            n_err++;
            $display("FAIL same_cycle_b: got bvalid=%b bresp=%b expected 1/00", v, r);
        end
        n_cmp++;
        if (wr_cnt !== exp_wr) begin
            n_err++;
            $display("FAIL same_cycle_wr_cnt: got %0d expected %0d", wr_cnt, exp_wr);
        end
        do_read(64'h40, d, r, v);
        n_cmp++;
        if ({v, r} !== 3'b100 || d !== pat_a5) begin
            n_err++;
            $display("FAIL same_cycle_r: got v=%b resp=%b data=%h expected 1/00/%h", v, r, d, pat_a5);
        end
        n_cmp++;
        if (rd_cnt !== exp_rd) begin
            n_err++;
            $display("FAIL same_cycle_rd_cnt: got %0d expected %0d", rd_cnt, exp_rd);
        end
    endtask

    task automatic test_w_first();
        logic [DW-1:0] d;
        logic [1:0]    r;
        logic          v;
        bus.wdata  = pat_ee11;
        bus.wstrb  = 64'h1;
        bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({bus.wready, bus.awready, bus.bvalid} !== 3'b010) begin
                n_err++;
                $display("FAIL w_first_wait%0d: got wready/awready/bvalid=%b expected 010", k,
                         {bus.wready, bus.awready, bus.bvalid});
            end
            if (k < 2) @(negedge clk);
        end
        bus.awaddr  = 64'h80;
        bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        n_cmp++;
        if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== 5'b10000) begin
            n_err++;
            $display("FAIL w_first_b: got %b expected 10000",
                     {bus.bvalid, bus.bresp, bus.awready, bus.wready});
        end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        exp_wr = exp_wr + 32'd1;
        n_cmp++;
        if (wr_cnt !== exp_wr) begin
            n_err++;
            $display("FAIL w_first_wr_cnt: got %0d expected %0d", wr_cnt, exp_wr);
        end
        do_read(64'h80, d, r, v);
        n_cmp++;
        if (d !== pat_b0_11 || r !== 2'b00) begin
            n_err++;
            $display("FAIL w_first_data: got %h resp %b expected %h 00", d, r, pat_b0_11);
        end
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] d;
        logic [1:0]    r;
        logic          v;
        do_write(64'h400, pat_ff, '1, r, v);
        n_cmp++;
        if ({v, r} !== 3'b110) begin
            n_err++;
            $display("FAIL oor_bresp: got v=%b resp=%b expected 1/10", v, r);
        end
        do_read(64'h0, d, r, v);
        n_cmp++;
        if (d !== zero_w) begin
            n_err++;
            $display("FAIL oor_word0_untouched: got %h expected 0", d);
        end
        do_read(64'h40, d, r, v);
        n_cmp++;
        if (d !== pat_a5) begin
            n_err++;
            $display("FAIL oor_word1_untouched: got %h expected %h", d, pat_a5);
        end
        // SLVERR read, with rready held low for three cycles.
        bus.araddr  = 64'h400;
        bus.arvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({bus.rvalid, bus.rresp, bus.arready} !== 4'b1100 || bus.rdata !== zero_w) begin
                n_err++;
                $display("FAIL oor_r_hold%0d: got v/resp/arready=%b data=%h expected 1100 0", k,
                         {bus.rvalid, bus.rresp, bus.arready}, bus.rdata);
            end
            @(negedge clk);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        exp_rd = exp_rd + 32'd1;
        n_cmp++;
        if ({wr_cnt, rd_cnt} !== {exp_wr, exp_rd}) begin
            n_err++;
            $display("FAIL oor_cnts: got %0d/%0d expected %0d/%0d", wr_cnt, rd_cnt, exp_wr, exp_rd);
        end
    endtask

    task automatic test_bready_stall();
        logic [DW-1:0] d;
        logic [1:0]    r;
        logic          v;
        bus.awaddr  = 64'hC0;
        bus.awvalid = 1'b1;
        bus.wdata   = pat_3c;
        bus.wstrb   = '1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b0;
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if ({bus.bvalid, bus.bresp, bus.awready} !== 4'b1000) begin
                n_err++;
                $display("FAIL stall%0d: got bvalid/bresp/awready=%b expected 1000", k,
                         {bus.bvalid, bus.bresp, bus.awready});
            end
            @(negedge clk);
        end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        exp_wr = exp_wr + 32'd1;
        n_cmp++;
        if ({bus.bvalid, bus.awready} !== 2'b01 || wr_cnt !== exp_wr) begin
            n_err++;
            $display("FAIL stall_release: got bvalid/awready=%b wr_cnt=%0d expected 01 %0d",
                     {bus.bvalid, bus.awready}, wr_cnt, exp_wr);
        end
        do_read(64'hC0, d, r, v);
        n_cmp++;
        if (d !== pat_3c) begin
            n_err++;
            $display("FAIL stall_data: got %h expected %h", d, pat_3c);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        logic [1:0]    r;
        logic          v;
        // Write and read of word 1 sampled on the same edge.
        bus.awaddr  = 64'h40;
        bus.awvalid = 1'b1;
        bus.wdata   = pat_5a;
        bus.wstrb   = '1;
        bus.wvalid  = 1'b1;
        bus.araddr  = 64'h40;
        bus.arvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        n_cmp++;
        if ({bus.bvalid, bus.rvalid} !== 2'b11 || bus.rdata !== pat_a5) begin
            n_err++;
            $display("FAIL concurrent_old_data: got b/r=%b data=%h expected 11 %h",
                     {bus.bvalid, bus.rvalid}, bus.rdata, pat_a5);
        end
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        exp_wr = exp_wr + 32'd1;
        exp_rd = exp_rd + 32'd1;
        do_read(64'h40, d, r, v);
        n_cmp++;
        if (d !== pat_5a) begin
            n_err++;
            $display("FAIL concurrent_new_data: got %h expected %h", d, pat_5a);
        end
        // Streaming: valids and readies held high for four cycles gives two
        // writes and two reads; the second read sees the first write.
        bus.awaddr  = 64'h100;
        bus.awvalid = 1'b1;
        bus.wdata   = pat_42;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        bus.araddr  = 64'h100;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 2) begin
                n_cmp++;
                if (bus.rvalid !== 1'b1 || bus.rdata !== pat_42) begin
                    n_err++;
                    $display("FAIL stream_rdata: got v=%b %h expected 1 %h", bus.rvalid, bus.rdata, pat_42);
                end
            end
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        bus.bready  = 1'b0;
        bus.rready  = 1'b0;
        exp_wr = exp_wr + 32'd2;
        exp_rd = exp_rd + 32'd2;
        n_cmp++;
        if ({wr_cnt, rd_cnt} !== {exp_wr, exp_rd}) begin
            n_err++;
            $display("FAIL stream_cnts: got %0d/%0d expected %0d/%0d", wr_cnt, rd_cnt, exp_wr, exp_rd);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        logic [1:0]    r;
        logic          v;
        bus.awaddr  = 64'h40;
        bus.awvalid = 1'b1;
        bus.wdata   = pat_77;
        bus.wstrb   = '1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b0;
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        n_cmp++;
        if (bus.bvalid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre_bvalid: got %b expected 1", bus.bvalid);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp} !== 7'b0
            || bus.rdata !== zero_w) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got %b expected 0",
                     {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp});
        end
        n_cmp++;
        if ({wr_cnt, rd_cnt} !== 64'd0) begin
            n_err++;
            $display("FAIL mid_reset_cnt: got %0d/%0d expected 0/0", wr_cnt, rd_cnt);
        end
        bus.bready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        exp_wr = 32'd0;
        exp_rd = 32'd0;
        @(negedge clk);
        n_cmp++;
        if ({bus.awready, bus.bvalid} !== 2'b10 || wr_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL mid_after: got awready/bvalid=%b wr_cnt=%0d expected 10 0",
                     {bus.awready, bus.bvalid}, wr_cnt);
        end
        bus.bready = 1'b0;
        do_read(64'h40, d, r, v);
        n_cmp++;
        if (d !== zero_w || r !== 2'b00) begin
            n_err++;
            $display("FAIL mid_word1: got %h resp %b expected 0 00", d, r);
        end
        n_cmp++;
        if ({wr_cnt, rd_cnt} !== {exp_wr, exp_rd}) begin
            n_err++;
            $display("FAIL mid_cnts: got %0d/%0d expected %0d/%0d", wr_cnt, rd_cnt, exp_wr, exp_rd);
        end
    endtask

    task automatic test_cnt_wrap();
        logic [DW-1:0] d;
        logic [1:0]    r;
        logic          v;
        force dut.rd_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.rd_cnt_q;
        #1;
        n_cmp++;
        if (rd_cnt !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL wrap_preset: got %h expected ffffffff", rd_cnt);
        end
        do_read(64'h0, d, r, v);
        n_cmp++;
        if (rd_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL wrap_rd_cnt: got %h expected 0", rd_cnt);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.araddr  = '0;
        bus.arprot  = 3'b0;
        bus.arvalid = 1'b0;
        bus.awaddr  = '0;
        bus.awprot  = 3'b0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.rready  = 1'b0;

        test_reset();
        test_same_cycle();
        test_w_first();
        test_out_of_range();
        test_bready_stall();
        test_back_to_back();
        test_reset_mid();
        test_cnt_wrap();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_l_slave_bfm.md
AXI_L_SLAVE_BFM -- requirements
Module: axi_l_slave_bfm

Interface
REQ-001 Parameter DATA_WIDTH, default 512, SHALL set the R/W data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 64, SHALL set the AR/AW address width.
REQ-003 Parameter MASK_WIDTH, default DATA_WIDTH/8, SHALL set the wstrb width.
REQ-004 Parameter MEM_DEPTH, default 16, SHALL set the number of DATA_WIDTH-wide memory words (power of 2).
REQ-005 Port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Ports araddr (input, ADDR_WIDTH), arprot (input, 3, ignored), arvalid (input, 1), arready (output, 1): AR channel.
REQ-008 Ports awaddr (input, ADDR_WIDTH), awprot (input, 3, ignored), awvalid (input, 1), awready (output, 1): AW channel.
REQ-009 Ports wdata (input, DATA_WIDTH), wstrb (input, MASK_WIDTH), wvalid (input, 1), wready (output, 1): W channel.
REQ-010 Ports bresp (output, 2), bvalid (output, 1), bready (input, 1): B channel.
REQ-011 Ports rdata (output, DATA_WIDTH), rresp (output, 2), rvalid (output, 1), rready (input, 1): R channel.
REQ-012 Ports wr_cnt and rd_cnt (output, 32 each) SHALL count completed B and R handshakes.

Function
REQ-013 Word index SHALL be addr >> log2(MASK_WIDTH); low byte-offset bits are ignored.
REQ-014 An address is in range when its word index < MEM_DEPTH; otherwise the response SHALL be SLVERR (2'b10) and no memory access occurs.
REQ-015 Write FSM states SHALL be W_COLLECT and W_RESP; AW and W are captured independently, in either order or in the same cycle.
REQ-016 In W_COLLECT, awready SHALL be 1 until an AW handshake is captured and 0 afterwards; wready behaves the same for W.
REQ-017 In the cycle after both AW and W are held, the FSM SHALL enter W_RESP, update the memory and assert bvalid, with awready=wready=0.
REQ-018 The memory update SHALL write byte i only where wstrb[i]=1; wstrb=0 SHALL give OKAY with no change.
REQ-019 bvalid and bresp SHALL stay stable until bready; on the handshake the FSM returns to W_COLLECT, wr_cnt increments, and awready/wready are 1 in the next cycle.
REQ-020 Read FSM states SHALL be R_IDLE (arready=1) and R_RESP (arready=0).
REQ-021 On an AR handshake, the next cycle SHALL show rvalid=1 and rdata = mem[index] with rresp OKAY, or rdata=0 with rresp SLVERR if out of range.
REQ-022 rvalid, rdata and rresp SHALL stay stable until rready; on the handshake the FSM returns to R_IDLE and rd_cnt increments.
REQ-023 Read and write FSMs SHALL operate concurrently; a read sampling the same word in the cycle of a write update SHALL return the pre-write data.
REQ-024 wr_cnt and rd_cnt SHALL wrap from 0xFFFFFFFF to 0.
REQ-025 Sustained throughput SHALL be one write per 2 cycles and one read per 2 cycles when bready=rready=1.

Reset
REQ-026 While rst_n=0, all outputs SHALL be 0, both FSMs SHALL be in their idle state, all captured flags SHALL be cleared, and all memory words SHALL be 0.
REQ-027 awready, wready and arready SHALL first go to 1 on the first clk edge after rst_n deasserts.
REQ-028 Reset asserted mid-transaction SHALL abandon it immediately; no partial write and no B/R response after the reset.

Verification
REQ-029 AW 0x40 and W 0xA5.. with all strobes set in the same cycle, then AR 0x40 -> bvalid one cycle after the handshake with bresp 0, rdata all 0xA5, wr_cnt=1, rd_cnt=1.
REQ-030 W 3 cycles before AW to 0x80 with wstrb=1 and data 0x11 -> wready=0 until AW; byte0 of word 2 = 0x11, other bytes 0.
REQ-031 AW 0x400 with MEM_DEPTH=16 (index 16) -> bresp=2'b10 and memory unchanged; AR 0x400 -> rresp=2'b10, rdata=0.
REQ-032 bready held 0 for 5 cycles -> bvalid/bresp stable and awready=0 throughout; B completes on the cycle bready rises.
REQ-033 rst_n pulsed low while in W_RESP after writing word 1 -> all outputs 0, word 1 reads 0 after reset, wr_cnt=0.
REQ-034 Preset rd_cnt to 0xFFFFFFFF via forced reads, then one more read -> rd_cnt=0.
